// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single data-memory port between the CPU data port (port 0,
//   priority) and a DMA/loader port (port 1). One transaction at a time:
//   IDLE captures the winning request, ACCESS drives the memory strobes for
//   one cycle, and WAIT (reads only) returns the memory word to the winner.
//   A starvation counter lets a waiting DMA request beat the CPU.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   cpu_* / dma_*         requester ports: req, write, addr, wdata, byteen in;
//                         gnt (1-cycle accept pulse), rvalid (1-cycle pulse),
//                         rdata (holds last read) out
//   mem_address           word-aligned address to memory
//   mem_write, mem_read   one-cycle strobes, never both high
//   mem_writedata/byteen  write data and byte enables to memory
//   mem_readdata          memory read data, valid READ_LATENCY cycles after mem_read
module data_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_write,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_byteen,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    input  logic                    dma_req,
    input  logic                    dma_write,
    input  logic [ADDR_WIDTH-1:0]   dma_addr,
    input  logic [DATA_WIDTH-1:0]   dma_wdata,
    input  logic [DATA_WIDTH/8-1:0] dma_byteen,
    output logic                    dma_gnt,
    output logic                    dma_rvalid,
    output logic [DATA_WIDTH-1:0]   dma_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [DATA_WIDTH-1:0]   mem_writedata,
    output logic [DATA_WIDTH/8-1:0] mem_byteen,
    input  logic [DATA_WIDTH-1:0]   mem_readdata
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    port_q;      // 0 = CPU owns the transaction, 1 = DMA
    logic [LW-1:0]           wait_cnt_q;
    logic [SW-1:0]           starve_q, starve_d;

    logic                    cpu_gnt_q, dma_gnt_q;
    logic                    cpu_rvalid_q, dma_rvalid_q;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, dma_rdata_q;
    logic [ADDR_WIDTH-1:0]   mem_address_q;
    logic                    mem_write_q, mem_read_q;
    logic [DATA_WIDTH-1:0]   mem_writedata_q;
    logic [BW-1:0]           mem_byteen_q;

    logic                    dma_wins;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [BW-1:0]           sel_byteen;

    // DMA wins when it is alone, or when it has waited long enough.
    assign dma_wins = dma_req && (!cpu_req || (starve_q >= SW'(STARVE_LIMIT)));

    always_comb begin
        sel_write  = cpu_write;
        sel_addr   = cpu_addr;
        sel_wdata  = cpu_wdata;
        sel_byteen = cpu_byteen;
        if (dma_wins) begin
            sel_write  = dma_write;
            sel_addr   = dma_addr;
            sel_wdata  = dma_wdata;
            sel_byteen = dma_byteen;
        end
    end

    // Counts every cycle DMA is asking but not granted, busy cycles included.
    always_comb begin
        starve_d = starve_q;
        if (!dma_req || dma_gnt_q) begin
            starve_d = '0;
        end else if (starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            port_q          <= 1'b0;
            wait_cnt_q      <= '0;
            starve_q        <= '0;
            cpu_gnt_q       <= 1'b0;
            dma_gnt_q       <= 1'b0;
            cpu_rvalid_q    <= 1'b0;
            dma_rvalid_q    <= 1'b0;
            cpu_rdata_q     <= '0;
            dma_rdata_q     <= '0;
            mem_address_q   <= '0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_writedata_q <= '0;
            mem_byteen_q    <= '0;
        end else begin
            starve_q     <= starve_d;
            // Strobes and pulses last exactly one cycle unless re-asserted below.
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req || dma_req) begin
                        // The memory-side registers double as the request capture.
                        port_q          <= dma_wins;
                        cpu_gnt_q       <= !dma_wins;
                        dma_gnt_q       <= dma_wins;
                        mem_address_q   <= sel_addr & ~ADDR_WIDTH'(3);
                        mem_writedata_q <= sel_wdata;
                        mem_byteen_q    <= sel_byteen;
                        mem_write_q     <= sel_write;
                        mem_read_q      <= !sel_write;
                        state_q         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_read_q) begin
                        wait_cnt_q <= LW'(1);
                        state_q    <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == LW'(READ_LATENCY)) begin
                        if (port_q) begin
                            dma_rdata_q  <= mem_readdata;
                            dma_rvalid_q <= 1'b1;
                        end else begin
                            cpu_rdata_q  <= mem_readdata;
                            cpu_rvalid_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_gnt       = cpu_gnt_q;
    assign dma_gnt       = dma_gnt_q;
    assign cpu_rvalid    = cpu_rvalid_q;
    assign dma_rvalid    = dma_rvalid_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign dma_rdata     = dma_rdata_q;
    assign mem_address   = mem_address_q;
    assign mem_write     = mem_write_q;
    assign mem_read      = mem_read_q;
    assign mem_writedata = mem_writedata_q;
    assign mem_byteen    = mem_byteen_q;

endmodule
